iq_loopback_buffer_ble: RTL and testbench
=========================================

IQ_LOOPBACK_BUFFER_BLE -- requirements
Module: iq_loopback_buffer_ble

Interface
REQ-001 Parameter RE_IM_SIZE, default 12: bit width of each I and Q sample.
REQ-002 Parameter AD, default 8: buffer address width; DEPTH = 2**AD samples.
REQ-003 Parameter PACE, default 2 (legal range 1..15): clock cycles between replayed samples.
REQ-004 Parameter GAP, default 4 (legal range 0..255): idle cycles between end of capture and first replay pacing cycle.
REQ-005 clk  in  1  single block clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  block enable; low aborts any activity.
REQ-008 clear  in  1  synchronous abort that also clears the overflow flag.
REQ-009 valid_in  in  1  TX mapper sample strobe.
REQ-010 data_in_re / data_in_im  in  RE_IM_SIZE each  TX I/Q sample.
REQ-011 frame_done  in  1  end-of-frame pulse from the TX chain (tx_irq_pulse).
REQ-012 valid_out_re / valid_out_im  out  1 each  replay strobes to the RX chain; always equal.
REQ-013 data_out_re / data_out_im  out  RE_IM_SIZE each  replayed I/Q sample.
REQ-014 sample_count  out  AD+1  number of samples stored in the current frame.
REQ-015 overflow  out  1  sticky flag: a sample arrived while the buffer was full.
REQ-016 replay_done  out  1  one-cycle pulse after the last replayed sample.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The block SHALL implement the FSM states IDLE, CAPTURE, GAP_WAIT, REPLAY and DONE.
REQ-019 In IDLE with enable=1, valid_in SHALL write the sample to address 0, set sample_count=1 and move to CAPTURE; in IDLE, frame_done SHALL be ignored.
REQ-020 In CAPTURE, each valid_in with sample_count<DEPTH SHALL write the sample to address sample_count and increment sample_count.
REQ-021 In CAPTURE, valid_in with sample_count==DEPTH SHALL drop the sample and set overflow=1; overflow SHALL hold until clear or reset.
REQ-022 In CAPTURE, frame_done SHALL move the FSM to GAP_WAIT; when valid_in and frame_done are coincident, the sample SHALL be stored first.
REQ-023 GAP_WAIT SHALL last exactly GAP cycles (0 means zero cycles, so the FSM enters REPLAY directly) and then move to REPLAY with the read pointer at 0.
REQ-024 Every valid_in arriving outside IDLE and CAPTURE SHALL be discarded without setting overflow.
REQ-025 REPLAY SHALL assert valid_out_re and valid_out_im for exactly one cycle every PACE cycles, with the first strobe PACE cycles after REPLAY is entered.
REQ-026 The data outputs SHALL be registered, SHALL present the sample at the read pointer in the strobe cycle, and SHALL hold their value between strobes.
REQ-027 Samples SHALL be replayed in capture order from address 0 to sample_count-1; the read pointer increments after each strobe.
REQ-028 After the strobe for address sample_count-1, the FSM SHALL enter DONE. DONE SHALL pulse replay_done for one cycle, then return to IDLE with sample_count=0.
REQ-029 With PACE=1, strobes SHALL occur on consecutive cycles.
REQ-030 enable=0 or clear=1 in any state SHALL force IDLE on the next edge, zero sample_count and both pointers, and deassert the strobes, with no replay_done pulse; clear additionally zeroes overflow.
REQ-031 clear SHALL take priority over every other input.
REQ-032 Buffer contents SHALL NOT be reset; only the pointers, counters and outputs are reset.

Reset
REQ-033 Asserting reset SHALL immediately set the FSM to IDLE and zero all pointers, counters and outputs (data_out_*, valid_out_*, sample_count, overflow, replay_done, busy).
REQ-034 Deasserting reset SHALL take effect synchronously; the first capture is possible on the first edge after deassertion.

Structure
REQ-035 The FSM state encodings and the PACE/GAP counter widths SHALL live in the shared BLE PHY package.
REQ-036 The sample storage SHALL be one sub-module, iq_sample_ram_ble: dual-port with 1 write port and 1 synchronous read port, 2*RE_IM_SIZE bits wide, DEPTH deep.
REQ-037 The FSM, pacing counter and pointers SHALL reside in the top module.

Verification
REQ-038 Capture and replay: 5 samples (re=1..5, im=-1..-5), frame_done, GAP=4, PACE=2 -> after 4 idle cycles, 5 strobes 2 cycles apart carrying 1..5/-1..-5, then a replay_done pulse; sample_count=5 during replay and 0 afterwards.
REQ-039 Buffer full: AD=2, 6 samples -> sample_count=4, overflow=1, and the first 4 samples are replayed; clear -> overflow=0.
REQ-040 Coincident events: valid_in and frame_done in the same cycle (3rd sample) -> 3 samples are replayed.
REQ-041 Abort: enable dropped after the 2nd replay strobe -> busy=0 on the next cycle, no further strobes, no replay_done.
REQ-042 Reset mid-replay: reset asserted -> all outputs 0 immediately; a new 2-sample frame after release replays correctly.
REQ-043 Edge parameters: PACE=1, GAP=0, 3 samples -> strobes on 3 consecutive cycles, the first 1 cycle after frame_done registers.

Source files
------------

// File: rtl/iq_loopback_buffer_ble_pkg.sv
// Shared BLE PHY definitions for the IQ loopback buffer:
//   state_t - loopback FSM states
//   pace_t  - replay pacing counter (PACE up to 15)
//   gap_t   - capture-to-replay gap counter (GAP up to 255)
package iq_loopback_buffer_ble_pkg;

  localparam int unsigned PACE_W = 4;
  localparam int unsigned GAP_W  = 8;

  typedef logic [PACE_W-1:0] pace_t;
  typedef logic [GAP_W-1:0]  gap_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    GAP_WAIT = 3'd2,
    REPLAY   = 3'd3,
    DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/iq_sample_ram_ble.sv
// IQ sample storage: simple dual-port RAM, one write port and one
// synchronous read port. Contents are never reset.
//   clk     - clock
//   we      - write enable
//   wr_addr - write address
//   wr_data - write data ({re, im})
//   rd_addr - read address, sampled on the rising edge
//   rd_data - read data, valid the cycle after rd_addr is presented
module iq_sample_ram_ble #(
  parameter int unsigned W  = 24,
  parameter int unsigned AD = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AD-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AD-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [2**AD];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/iq_loopback_buffer_ble.sv
// IQ loopback buffer: captures one TX frame of I/Q samples, waits GAP
// cycles after frame_done, then replays the frame towards the RX chain
// with one strobe every PACE cycles.
//   clk, reset                 - clock, async active-high reset
//   enable, clear              - block enable / synchronous abort (+ overflow clear)
//   valid_in, data_in_re/_im   - TX sample strobe and I/Q sample
//   frame_done                 - end-of-frame pulse from TX
//   valid_out_re/_im           - replay strobes (always equal)
//   data_out_re/_im            - registered replayed sample
//   sample_count               - samples stored in the current frame
//   overflow                   - sticky: sample arrived with buffer full
//   replay_done                - one-cycle pulse after the last replayed sample
//   busy                       - high outside IDLE
module iq_loopback_buffer_ble
  import iq_loopback_buffer_ble_pkg::*;
#(
  parameter int unsigned RE_IM_SIZE = 12,
  parameter int unsigned AD         = 8,
  parameter int unsigned PACE       = 2,
  parameter int unsigned GAP        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  valid_in,
  input  logic [RE_IM_SIZE-1:0] data_in_re,
  input  logic [RE_IM_SIZE-1:0] data_in_im,
  input  logic                  frame_done,
  output logic                  valid_out_re,
  output logic                  valid_out_im,
  output logic [RE_IM_SIZE-1:0] data_out_re,
  output logic [RE_IM_SIZE-1:0] data_out_im,
  output logic [AD:0]           sample_count,
  output logic                  overflow,
  output logic                  replay_done,
  output logic                  busy
);

  typedef logic [AD:0] cnt_t;

  localparam pace_t PACE_LAST = pace_t'(PACE - 1);
  localparam gap_t  GAP_LAST  = gap_t'((GAP == 0) ? 0 : GAP - 1);

  state_t state, state_next;
  cnt_t   count_next;
  cnt_t   rd_ptr, rd_ptr_next;
  pace_t  pace_cnt, pace_next;
  gap_t   gap_cnt, gap_next;
  logic   strobe;
  logic   valid_out;
  logic   we;
  logic   ovf_set;

  logic [2*RE_IM_SIZE-1:0] rd_data;

  // The RAM is addressed with the next read pointer so that its registered
  // output already holds the sample for the upcoming strobe, even when
  // strobes come on consecutive cycles.
  iq_sample_ram_ble #(
    .W  (2 * RE_IM_SIZE),
    .AD (AD)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (sample_count[AD-1:0]),
    .wr_data ({data_in_re, data_in_im}),
    .rd_addr (rd_ptr_next[AD-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_next  = state;
    count_next  = sample_count;
    rd_ptr_next = rd_ptr;
    pace_next   = pace_cnt;
    gap_next    = gap_cnt;
    strobe      = 1'b0;
    we          = 1'b0;
    ovf_set     = 1'b0;
    if (clear || !enable) begin
      state_next  = IDLE;
      count_next  = '0;
      rd_ptr_next = '0;
      pace_next   = '0;
      gap_next    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_in) begin
            we         = 1'b1;
            count_next = cnt_t'(1);
            state_next = CAPTURE;
          end
        end
        CAPTURE: begin
          if (valid_in) begin
            // sample_count never exceeds DEPTH, so its MSB flags "full"
            if (!sample_count[AD]) begin
              we         = 1'b1;
              count_next = sample_count + cnt_t'(1);
            end else begin
              ovf_set = 1'b1;
            end
          end
          if (frame_done) begin
            state_next  = (GAP == 0) ? REPLAY : GAP_WAIT;
            gap_next    = '0;
            pace_next   = '0;
            rd_ptr_next = '0;
          end
        end
        GAP_WAIT: begin
          if (gap_cnt == GAP_LAST) begin
            state_next = REPLAY;
            gap_next   = '0;
          end else begin
            gap_next = gap_cnt + gap_t'(1);
          end
        end
        REPLAY: begin
          // Pointer reaching the count means the last strobe has just gone out
          if (rd_ptr == sample_count) begin
            state_next = DONE;
          end else if (pace_cnt == PACE_LAST) begin
            strobe      = 1'b1;
            pace_next   = '0;
            rd_ptr_next = rd_ptr + cnt_t'(1);
          end else begin
            pace_next = pace_cnt + pace_t'(1);
          end
        end
        DONE: begin
          state_next  = IDLE;
          count_next  = '0;
          rd_ptr_next = '0;
          pace_next   = '0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sample_count <= '0;
      rd_ptr       <= '0;
      pace_cnt     <= '0;
      gap_cnt      <= '0;
      valid_out    <= 1'b0;
      data_out_re  <= '0;
      data_out_im  <= '0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_next;
      sample_count <= count_next;
      rd_ptr       <= rd_ptr_next;
      pace_cnt     <= pace_next;
      gap_cnt      <= gap_next;
      valid_out    <= strobe;
      if (strobe) begin
        data_out_re <= rd_data[2*RE_IM_SIZE-1:RE_IM_SIZE];
        data_out_im <= rd_data[RE_IM_SIZE-1:0];
      end
      if (clear) begin
        overflow <= 1'b0;
      end else if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

  assign valid_out_re = valid_out;
  assign valid_out_im = valid_out;
  assign replay_done  = (state == DONE);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_iq_loopback_buffer_ble.sv
// Testbench for iq_loopback_buffer_ble. Two instances share the inputs:
//   dut_a - defaults (AD=8, PACE=2, GAP=4)
//   dut_b - AD=2, PACE=1, GAP=0 (buffer-full and back-to-back replay cases)
module tb_iq_loopback_buffer_ble;

  logic        clk = 1'b0;
  logic        reset, enable, clear, valid_in, frame_done;
  logic [11:0] din_re, din_im;

  logic        voa_re, voa_im, ovfa, donea, busya;
  logic [11:0] doa_re, doa_im;
  logic [8:0]  cnta;
  logic        vob_re, vob_im, ovfb, doneb, busyb;
  logic [11:0] dob_re, dob_im;
  logic [2:0]  cntb;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  iq_loopback_buffer_ble #(.RE_IM_SIZE(12), .AD(8), .PACE(2), .GAP(4)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .valid_in(valid_in),
    .data_in_re(din_re), .data_in_im(din_im), .frame_done(frame_done),
    .valid_out_re(voa_re), .valid_out_im(voa_im), .data_out_re(doa_re), .data_out_im(doa_im),
    .sample_count(cnta), .overflow(ovfa), .replay_done(donea), .busy(busya)
  );

  iq_loopback_buffer_ble #(.RE_IM_SIZE(12), .AD(2), .PACE(1), .GAP(0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .valid_in(valid_in),
    .data_in_re(din_re), .data_in_im(din_im), .frame_done(frame_done),
    .valid_out_re(vob_re), .valid_out_im(vob_im), .data_out_re(dob_re), .data_out_im(dob_im),
    .sample_count(cntb), .overflow(ovfb), .replay_done(doneb), .busy(busyb)
  );

  typedef struct {
    bit v; bit fd; int re; int im;
    bit vo; int dre; int dim; int cnt; bit bsy; bit done;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t row(bit v, bit fd, int re, int im,
                               bit vo, int dre, int dim, int cnt, bit bsy, bit done);
    vec_t r;
    r.v = v; r.fd = fd; r.re = re; r.im = im;
    r.vo = vo; r.dre = dre; r.dim = dim; r.cnt = cnt; r.bsy = bsy; r.done = done;
    return r;
  endfunction

  function automatic logic [31:0] d12(int x);
    return {20'd0, 12'(x)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_all(input string t,
                         input logic avre, input logic avim, input logic [11:0] are,
                         input logic [11:0] aim, input logic [8:0] acnt, input logic aovf,
                         input logic absy, input logic adone,
                         input bit vo, input int dre, input int dim, input int cnt,
                         input bit ovf, input bit bsy, input bit done);
    check({t, "_vo_re"}, 32'(avre), 32'(vo));
    check({t, "_vo_im"}, 32'(avim), 32'(vo));
    check({t, "_data_re"}, 32'(are), d12(dre));
    check({t, "_data_im"}, 32'(aim), d12(dim));
    check({t, "_count"}, 32'(acnt), 32'(cnt));
    check({t, "_overflow"}, 32'(aovf), 32'(ovf));
    check({t, "_busy"}, 32'(absy), 32'(bsy));
    check({t, "_replay_done"}, 32'(adone), 32'(done));
  endtask

  task automatic check_a(input string t, input bit vo, input int dre, input int dim,
                         input int cnt, input bit ovf, input bit bsy, input bit done);
    cmp_all(t, voa_re, voa_im, doa_re, doa_im, cnta, ovfa, busya, donea,
            vo, dre, dim, cnt, ovf, bsy, done);
  endtask

  task automatic check_b(input string t, input bit vo, input int dre, input int dim,
                         input int cnt, input bit ovf, input bit bsy, input bit done);
    cmp_all(t, vob_re, vob_im, dob_re, dob_im, {6'd0, cntb}, ovfb, busyb, doneb,
            vo, dre, dim, cnt, ovf, bsy, done);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit fd, input int re, input int im);
    valid_in   = v;
    frame_done = fd;
    din_re     = 12'(re);
    din_im     = 12'(im);
  endtask

  task automatic restart();
    drive(0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_vo, seen_done;

    // Capture/replay table for dut_a: 5 samples, GAP=4, PACE=2
    vq.push_back(row(1, 0, 1, -1,  0, 0, 0, 1, 1, 0));
    vq.push_back(row(1, 0, 2, -2,  0, 0, 0, 2, 1, 0));
    vq.push_back(row(1, 0, 3, -3,  0, 0, 0, 3, 1, 0));
    vq.push_back(row(1, 0, 4, -4,  0, 0, 0, 4, 1, 0));
    vq.push_back(row(1, 0, 5, -5,  0, 0, 0, 5, 1, 0));
    vq.push_back(row(0, 1, 0, 0,   0, 0, 0, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0,   0, 0, 0, 5, 1, 0));
    vq.push_back(row(1, 0, 9, 9,   0, 0, 0, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0,   0, 0, 0, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0,   0, 0, 0, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0,   0, 0, 0, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0,   1, 1, -1, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0,   0, 1, -1, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0,   1, 2, -2, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0,   0, 2, -2, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0,   1, 3, -3, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0,   0, 3, -3, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0,   1, 4, -4, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0,   0, 4, -4, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0,   1, 5, -5, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0,   0, 5, -5, 5, 1, 1));
    vq.push_back(row(0, 0, 0, 0,   0, 5, -5, 0, 0, 0));

    // Reset state
    reset  = 1'b1;
    enable = 1'b1;
    clear  = 1'b0;
    drive(0, 0, 0, 0);
    #2;
    check_a("rst_a", 0, 0, 0, 0, 0, 0, 0);
    check_b("rst_b", 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].fd, vq[i].re, vq[i].im);
      step();
      check_a($sformatf("A%0d", i), vq[i].vo, vq[i].dre, vq[i].dim, vq[i].cnt, 0,
              vq[i].bsy, vq[i].done);
    end

    // Buffer full on dut_b (DEPTH=4), back-to-back replay, then clear
    restart();
    for (int i = 1; i <= 6; i++) begin
      drive(1, 0, i, -i);
      step();
      check_b($sformatf("B_cap%0d", i), 0, 0, 0, (i > 4) ? 4 : i, i > 4, 1, 0);
    end
    drive(0, 1, 0, 0);
    step();
    check_b("B_fd", 0, 0, 0, 4, 1, 1, 0);
    drive(0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check_b($sformatf("B_rep%0d", k), 1, k, -k, 4, 1, 1, 0);
    end
    step();
    check_b("B_done", 0, 4, -4, 4, 1, 1, 1);
    step();
    check_b("B_idle", 0, 4, -4, 0, 1, 0, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_b("B_clear", 0, 4, -4, 0, 0, 0, 0);

    // Coincident valid_in/frame_done on the 3rd sample, PACE=1 GAP=0
    drive(1, 0, 7, -7);
    step();
    check_b("C_cap1", 0, 4, -4, 1, 0, 1, 0);
    drive(1, 0, 8, -8);
    step();
    check_b("C_cap2", 0, 4, -4, 2, 0, 1, 0);
    drive(1, 1, 9, -9);
    step();
    check_b("C_cap3", 0, 4, -4, 3, 0, 1, 0);
    drive(0, 0, 0, 0);
    for (int k = 7; k <= 9; k++) begin
      step();
      check_b($sformatf("C_rep%0d", k), 1, k, -k, 3, 0, 1, 0);
    end
    step();
    check_b("C_done", 0, 9, -9, 3, 0, 1, 1);
    step();
    check_b("C_idle", 0, 9, -9, 0, 0, 0, 0);

    // Abort by enable after the 2nd replay strobe (dut_a)
    restart();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 20 + i, -(20 + i));
      step();
    end
    check_a("D_cap", 0, 0, 0, 3, 0, 1, 0);
    drive(0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0);
    repeat (5) step();
    check_a("D_pre", 0, 0, 0, 3, 0, 1, 0);
    step();
    check_a("D_rep1", 1, 20, -20, 3, 0, 1, 0);
    step();
    step();
    check_a("D_rep2", 1, 21, -21, 3, 0, 1, 0);
    enable = 1'b0;
    step();
    check_a("D_abort", 0, 21, -21, 0, 0, 0, 0);
    enable = 1'b1;
    seen_vo   = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      seen_vo   |= (voa_re | voa_im);
      seen_done |= donea;
    end
    check("D_no_strobe", 32'(seen_vo), 32'd0);
    check("D_no_done", 32'(seen_done), 32'd0);
    check("D_busy_after", 32'(busya), 32'd0);

    // Reset mid-replay, then a fresh 2-sample frame (dut_a)
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 30 + i, -(30 + i));
      step();
    end
    drive(0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0);
    repeat (6) step();
    check_a("E_rep1", 1, 30, -30, 3, 0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    check_a("E_reset", 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    drive(1, 0, 40, -40);
    step();
    check_a("E_cap1", 0, 0, 0, 1, 0, 1, 0);
    drive(1, 1, 41, -41);
    step();
    check_a("E_cap2", 0, 0, 0, 2, 0, 1, 0);
    drive(0, 0, 0, 0);
    repeat (5) step();
    check_a("E_pre", 0, 0, 0, 2, 0, 1, 0);
    step();
    check_a("E_rep40", 1, 40, -40, 2, 0, 1, 0);
    step();
    check_a("E_hold", 0, 40, -40, 2, 0, 1, 0);
    step();
    check_a("E_rep41", 1, 41, -41, 2, 0, 1, 0);
    step();
    check_a("E_done", 0, 41, -41, 2, 0, 1, 1);
    step();
    check_a("E_idle", 0, 41, -41, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
